lcd_timed_ctrl: RTL and testbench

- Avalon-MM slave that drives an HD44780-style character LCD. Every bus access becomes one full LCD bus cycle: address/data setup, timed E pulse, hold, then an enforced recovery gap.
- waitrequest stretches the bus access, so software no longer needs delay loops between LCD accesses.
- Sits between the system interconnect and the LCD pins, in place of the bare, untimed LCD slave.

---
 rtl/lcd_timed_ctrl.sv | 95 +++++++++
 tb/tb_lcd_timed_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/lcd_timed_ctrl.sv
// Avalon-MM slave for an HD44780-style LCD: each bus access becomes one timed
// LCD bus cycle (setup, E pulse, hold, recovery) with waitrequest stretching it.
module lcd_timed_ctrl #(
    parameter int DATA_W     = 8,
    parameter int SETUP_CYC  = 2,
    parameter int E_HIGH_CYC = 12,
    parameter int HOLD_CYC   = 2,
    parameter int RECOV_CYC  = 10,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              waitrequest,
    output logic              LCD_E,
    output logic              LCD_RS,
    output logic              LCD_RW,
    inout  wire  [DATA_W-1:0] LCD_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_EHIGH, S_HOLD, S_DONE, S_RECOV
    } state_t;

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EHIGH_LAST = CNT_W'(E_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] RECOV_LAST = CNT_W'((RECOV_CYC > 0) ? RECOV_CYC - 1 : 0);

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_rw;
    logic                r_rs;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                w_req;
    logic                w_active;
    logic                w_drive;

    assign w_req = read | write;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_req) w_next = S_SETUP;
            S_SETUP: if (r_cnt == SETUP_LAST) w_next = S_EHIGH;
            S_EHIGH: if (r_cnt == EHIGH_LAST) w_next = S_HOLD;
            S_HOLD:  if (r_cnt == HOLD_LAST) w_next = S_DONE;
            S_DONE:  w_next = (RECOV_CYC == 0) ? S_IDLE : S_RECOV;
            S_RECOV: if (r_cnt == RECOV_LAST) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rw    <= 1'b1;
            r_rs    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            // Counter restarts on every state entry and is parked at 0 in IDLE.
            if (w_next != r_state || r_state == S_IDLE)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
            if (r_state == S_IDLE && w_req) begin
                r_rw    <= address[0];
                r_rs    <= address[1];
                r_wdata <= writedata;
            end
            // Capture the pin value; on write cycles that is our own driven data.
            if (r_state == S_EHIGH && r_cnt == EHIGH_LAST)
                r_rdata <= LCD_data;
        end
    end

    assign w_active    = (r_state == S_SETUP) || (r_state == S_EHIGH) || (r_state == S_HOLD);
    assign w_drive     = w_active && !r_rw;
    assign LCD_E       = (r_state == S_EHIGH);
    assign LCD_RS      = r_rs;
    assign LCD_RW      = w_active ? r_rw : 1'b1;
    assign LCD_data    = w_drive ? r_wdata : {DATA_W{1'bz}};
    assign waitrequest = w_req && (r_state != S_DONE);
    assign readdata    = r_rdata;

endmodule

// File: tb/tb_lcd_timed_ctrl.sv
// Directed bench for lcd_timed_ctrl: default-timing instance plus a
// minimum-timing instance; an LCD model drives the bus whenever RW is high.
module tb_lcd_timed_ctrl;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic [1:0] address;
    logic       read, write, read2, write2;
    logic [7:0] writedata;
    logic [7:0] readdata, readdata2;
    logic       waitrequest, waitrequest2;
    logic       LCD_E, LCD_RS, LCD_RW, E2, RS2, RW2;
    wire  [7:0] lcd_bus;
    wire  [7:0] lcd_bus2;
    logic [7:0] model_val;

    // LCD model: drives the bus whenever the controller signals a read direction.
    assign lcd_bus  = LCD_RW ? model_val : 8'hzz;
    assign lcd_bus2 = RW2 ? 8'h00 : 8'hzz;

    int checks = 0;
    int errors = 0;

    lcd_timed_ctrl dut (
        .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
        .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest),
        .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_data(lcd_bus)
    );

    lcd_timed_ctrl #(.SETUP_CYC(1), .E_HIGH_CYC(1), .HOLD_CYC(1), .RECOV_CYC(0)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .read(read2), .write(write2),
        .writedata(writedata), .readdata(readdata2), .waitrequest(waitrequest2),
        .LCD_E(E2), .LCD_RS(RS2), .LCD_RW(RW2), .LCD_data(lcd_bus2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rise1, rise2, rwfall, wl, wlast, epulses, rwlow, busbad, cc;
        logic prev_e;

        reset_n = 1'b0; read = 1'b0; write = 1'b0; read2 = 1'b0; write2 = 1'b0;
        address = 2'b00; writedata = 8'h00; model_val = 8'h00;
        repeat (3) tick();
        chk("rst_E", LCD_E, 0);
        chk("rst_RW", LCD_RW, 1);
        chk("rst_RS", LCD_RS, 0);
        chk("rst_rdata", readdata, 0);
        chk("rst_bus", lcd_bus, 8'h00);
        chk("rst_wait", waitrequest, 0);
        chk("rst2_E", E2, 0);
        reset_n = 1'b1;
        tick();

        // Write 0x38 to the instruction register
        address = 2'b00; writedata = 8'h38; write = 1'b1;
        #1 chk("wr_wait_c0", waitrequest, 1);
        for (int c = 1; c <= 17; c++) begin
            tick();
            chk($sformatf("wr_E_c%0d", c), LCD_E, (c >= 3 && c <= 14));
            chk($sformatf("wr_RW_c%0d", c), LCD_RW, (c <= 16) ? 0 : 1);
            chk($sformatf("wr_RS_c%0d", c), LCD_RS, 0);
            chk($sformatf("wr_bus_c%0d", c), lcd_bus, (c <= 16) ? 8'h38 : 8'h00);
            chk($sformatf("wr_wait_c%0d", c), waitrequest, (c != 17));
            if (c == 14) chk("wr_rdata_c14", readdata, 8'h00);
            if (c == 15) chk("wr_rdata_c15", readdata, 8'h38);
        end
        write = 1'b0;
        repeat (12) tick();

        // Read from the data register; model returns 0x41
        model_val = 8'h41; address = 2'b11; writedata = 8'hA5; read = 1'b1;
        #1 chk("rd_wait_c0", waitrequest, 1);
        for (int c = 1; c <= 17; c++) begin
            tick();
            chk($sformatf("rd_RW_c%0d", c), LCD_RW, 1);
            chk($sformatf("rd_RS_c%0d", c), LCD_RS, 1);
            chk($sformatf("rd_bus_c%0d", c), lcd_bus, 8'h41);
            chk($sformatf("rd_E_c%0d", c), LCD_E, (c >= 3 && c <= 14));
            chk($sformatf("rd_wait_c%0d", c), waitrequest, (c != 17));
            if (c == 14) chk("rd_rdata_c14", readdata, 8'h38);
            if (c == 15) chk("rd_rdata_c15", readdata, 8'h41);
        end
        read = 1'b0;
        repeat (12) tick();
        model_val = 8'h00;

        // Back-to-back writes with request held
        address = 2'b00; writedata = 8'h55; write = 1'b1;
        rise1 = -1; rise2 = -1; rwfall = -1; wl = 0; wlast = -1; prev_e = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            tick();
            if (LCD_E && !prev_e) begin
                if (rise1 < 0) rise1 = c;
                else if (rise2 < 0) rise2 = c;
            end
            prev_e = LCD_E;
            if (c > 17 && !LCD_RW && rwfall < 0) rwfall = c;
            if (!waitrequest) begin
                wl++;
                if (c > 17) wlast = c;
            end
            if (c == 45) write = 1'b0;
        end
        chk("b2b_rise1", rise1, 3);
        chk("b2b_rise2", rise2, 31);
        chk("b2b_setup2", rwfall, 29);
        chk("b2b_waitlow_cnt", wl, 2);
        chk("b2b_waitlow2", wlast, 45);
        repeat (12) tick();

        // Minimum-timing instance
        address = 2'b00; writedata = 8'h38; write2 = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            chk($sformatf("sw_E_c%0d", c), E2, (c == 2 || c == 7));
            chk($sformatf("sw_wait_c%0d", c), waitrequest2, (c != 4 && c != 9));
            chk($sformatf("sw_RW_c%0d", c), RW2, (c <= 3 || (c >= 6 && c <= 8)) ? 0 : 1);
            if (c == 9) write2 = 1'b0;
        end
        repeat (4) tick();

        // Reset in the middle of a write, request held across it
        address = 2'b00; writedata = 8'h77; write = 1'b1;
        repeat (8) tick();
        chk("rstm_E_c8", LCD_E, 1);
        reset_n = 1'b0;
        tick();
        chk("rstm_E", LCD_E, 0);
        chk("rstm_bus", lcd_bus, 8'h00);
        chk("rstm_RW", LCD_RW, 1);
        chk("rstm_rdata", readdata, 8'h00);
        chk("rstm_wait", waitrequest, 1);
        reset_n = 1'b1;
        tick();
        chk("rstm_setup_RW", LCD_RW, 0);
        chk("rstm_setup_bus", lcd_bus, 8'h77);
        chk("rstm_setup_E", LCD_E, 0);
        cc = 10;
        while (waitrequest && cc < 60) begin
            tick();
            cc++;
        end
        chk("rstm_done_cycle", cc, 26);
        write = 1'b0;
        repeat (12) tick();

        // read and write together with address 01: one read cycle
        model_val = 8'h5A; address = 2'b01; writedata = 8'hC3; read = 1'b1; write = 1'b1;
        epulses = 0; wl = 0; rwlow = 0; busbad = 0; prev_e = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (LCD_E && !prev_e) epulses++;
            prev_e = LCD_E;
            if (!LCD_RW) rwlow++;
            if (lcd_bus !== 8'h5A) busbad++;
            if ((read || write) && !waitrequest) begin
                wl++;
                read = 1'b0;
                write = 1'b0;
            end
        end
        chk("both_epulses", epulses, 1);
        chk("both_waitlow", wl, 1);
        chk("both_rwlow", rwlow, 0);
        chk("both_busdrv", busbad, 0);
        chk("both_rdata", readdata, 8'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
